// File: rtl/handshake_pkg.sv
// Shared constants for the handshake dataflow components.
// Holds the COLLECT/EMIT state encoding for the end-synchronisation block.
package handshake_pkg;

    localparam logic STATE_COLLECT = 1'b0;
    localparam logic STATE_EMIT    = 1'b1;

    typedef enum logic {
        COLLECT = STATE_COLLECT,
        EMIT    = STATE_EMIT
    } sync_state_t;

endpackage

// File: rtl/handshake_token_flag.sv
// Sticky per-channel "token received" flag.
// Set by a transfer on its channel. Cleared when the round ends or on reset.
module handshake_token_flag (
    input  logic clk,
    input  logic rst,
    input  logic xfer,
    input  logic round_end,
    output logic flag
);

    // Clearing wins over setting. No channel can transfer while the round is ending.
    always_ff @(posedge clk) begin
        if (rst || round_end) begin
            flag <= 1'b0;
        end else if (xfer) begin
            flag <= 1'b1;
        end
    end

endmodule

// File: rtl/handshake_end_sync.sv
// Joins one result token with NUM_MEMS memory-completion tokens.
// Emits the result once every channel has delivered a token in the current round.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   COLLECT | accept the result token and the memory tokens, one per channel
//   EMIT    | present the stored result and stall all inputs until it is taken
module handshake_end_sync
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_MEMS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [NUM_MEMS-1:0]   mem_valid,
    output logic [NUM_MEMS-1:0]   mem_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    sync_state_t           state;
    logic                  collecting;
    logic                  data_flag;
    logic [NUM_MEMS-1:0]   mem_flag;
    logic                  ins_xfer;
    logic [NUM_MEMS-1:0]   mem_xfer;
    logic                  round_end;
    logic                  complete;
    logic [DATA_WIDTH-1:0] data_reg;

    // Readies come only from registered state. They never look at outs_ready.
    assign collecting = (state == COLLECT);
    assign ins_ready  = collecting && !data_flag;
    assign mem_ready  = collecting ? ~mem_flag : '0;

    assign ins_xfer   = ins_valid && ins_ready;
    assign mem_xfer   = mem_valid & mem_ready;
    assign round_end  = outs_valid && outs_ready;

    // Transfers landing at this edge count towards completing the round.
    assign complete   = (data_flag || ins_xfer) && (&(mem_flag | mem_xfer));

    handshake_token_flag u_data_flag (
        .clk       (clk),
        .rst       (rst),
        .xfer      (ins_xfer),
        .round_end (round_end),
        .flag      (data_flag)
    );

    for (genvar i = 0; i < NUM_MEMS; i++) begin : g_mem_flag
        handshake_token_flag u_mem_flag (
            .clk       (clk),
            .rst       (rst),
            .xfer      (mem_xfer[i]),
            .round_end (round_end),
            .flag      (mem_flag[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
        end else if (ins_xfer) begin
            data_reg <= ins;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            outs_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (complete) begin
                        state      <= EMIT;
                        outs_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (outs_ready) begin
                        state      <= COLLECT;
                        outs_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= COLLECT;
                    outs_valid <= 1'b0;
                end
            endcase
        end
    end

    // ins_ready is 0 in EMIT, so data_reg cannot change while it is being presented.
    assign outs = data_reg;

endmodule

// File: tb/tb_handshake_end_sync.sv
// Directed bench for handshake_end_sync using hand-computed expectations.
// It ends with a scoreboarded random run that checks token count and order.
module tb_handshake_end_sync;

    localparam int DW = 32;
    localparam int NM = 2;
    localparam int N_RND = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic [NM-1:0] mem_valid;
    logic [NM-1:0] mem_ready;
    logic [DW-1:0] outs;
    logic          outs_valid;
    logic          outs_ready;

    int n_chk = 0;
    int n_bad = 0;
    logic [DW-1:0] obs_q[$];

    logic [DW-1:0] rnd_data[N_RND];
    int            k;
    int            cyc;
    logic          fire_i;
    logic [NM-1:0] fire_m;

    always #5 clk = ~clk;

    handshake_end_sync #(
        .DATA_WIDTH (DW),
        .NUM_MEMS   (NM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record every output transfer. Inputs stay stable between drive points, so negedge sampling is safe.
    always @(negedge clk) begin
        if (!rst && outs_valid && outs_ready) obs_q.push_back(outs);
    end

    initial begin
        rst = 1'b1; ins = '0; ins_valid = 1'b0; mem_valid = '0; outs_ready = 1'b0;
        step(); step();
        chk("rst_ov",   64'(outs_valid), 64'(0));
        chk("rst_outs", 64'(outs),       64'(0));
        chk("rst_ir",   64'(ins_ready),  64'(1));
        chk("rst_mr",   64'(mem_ready),  64'(2'b11));
        rst = 1'b0;

        // All channels deliver in the same cycle.
        outs_ready = 1'b1; ins = 32'h07EA045C; ins_valid = 1'b1; mem_valid = 2'b11;
        step();
        ins_valid = 1'b0; mem_valid = '0;
        chk("t1_ov",   64'(outs_valid), 64'(1));
        chk("t1_outs", 64'(outs),       64'(32'h07EA045C));
        chk("t1_ir",   64'(ins_ready),  64'(0));
        chk("t1_mr",   64'(mem_ready),  64'(0));
        step();
        chk("t1_ov_drop", 64'(outs_valid), 64'(0));
        step(); step();
        chk("t1_cnt", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() == 1) chk("t1_val", 64'(obs_q[0]), 64'(32'h07EA045C));

        // Staggered arrivals: mem0 in cycle 2, ins in cycle 5, mem1 in cycle 9.
        obs_q.delete();
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("t2_ov_c%0d", c),  64'(outs_valid),   64'(c == 10));
            chk($sformatf("t2_mr0_c%0d", c), 64'(mem_ready[0]), 64'(!(c >= 3 && c <= 10)));
            if (c == 10) chk("t2_outs", 64'(outs), 64'(32'h1234));
            mem_valid = {c == 9, c == 2};
            ins_valid = (c == 5);
            ins       = 32'h1234;
            step();
        end
        ins_valid = 1'b0; mem_valid = '0;
        chk("t2_cnt", 64'(obs_q.size()), 64'(1));

        // Downstream backpressure for 6 cycles.
        obs_q.delete();
        outs_ready = 1'b0; ins = 32'hA5A50001; ins_valid = 1'b1; mem_valid = 2'b11;
        step();
        ins_valid = 1'b0; mem_valid = '0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("t3_ov_c%0d", c),   64'(outs_valid), 64'(1));
            chk($sformatf("t3_outs_c%0d", c), 64'(outs),       64'(32'hA5A50001));
            chk($sformatf("t3_ir_c%0d", c),   64'(ins_ready),  64'(0));
            chk($sformatf("t3_mr_c%0d", c),   64'(mem_ready),  64'(0));
            step();
        end
        outs_ready = 1'b1;
        chk("t3_ov_7", 64'(outs_valid), 64'(1));
        step();
        chk("t3_ov_after", 64'(outs_valid), 64'(0));
        chk("t3_ir_after", 64'(ins_ready),  64'(1));
        chk("t3_mr_after", 64'(mem_ready),  64'(2'b11));
        chk("t3_cnt",      64'(obs_q.size()), 64'(1));

        // A second data token is held upstream until the next round.
        obs_q.delete();
        outs_ready = 1'b0; ins = 32'h0001; ins_valid = 1'b1;
        step();
        ins = 32'hBEEF;
        chk("t4_ir_blk", 64'(ins_ready), 64'(0));
        step();
        chk("t4_ir_blk2", 64'(ins_ready), 64'(0));
        mem_valid = 2'b11;
        step();
        mem_valid = '0;
        chk("t4_ov",   64'(outs_valid), 64'(1));
        chk("t4_outs", 64'(outs),       64'(32'h0001));
        chk("t4_ir_e", 64'(ins_ready),  64'(0));
        outs_ready = 1'b1;
        step();
        chk("t4_bubble_ov", 64'(outs_valid), 64'(0));
        chk("t4_bubble_ir", 64'(ins_ready),  64'(1));
        step();
        ins_valid = 1'b0;
        chk("t4_ir_cap", 64'(ins_ready), 64'(0));
        mem_valid = 2'b11;
        step();
        mem_valid = '0;
        chk("t4_ov2",   64'(outs_valid), 64'(1));
        chk("t4_outs2", 64'(outs),       64'(32'hBEEF));
        step();
        chk("t4_cnt", 64'(obs_q.size()), 64'(2));
        if (obs_q.size() == 2) begin
            chk("t4_tok0", 64'(obs_q[0]), 64'(32'h0001));
            chk("t4_tok1", 64'(obs_q[1]), 64'(32'hBEEF));
        end

        // Reset in the middle of a round throws away the partial round.
        obs_q.delete();
        outs_ready = 1'b1; ins = 32'h5555AAAA; ins_valid = 1'b1; mem_valid = 2'b01;
        step();
        ins_valid = 1'b0; mem_valid = '0;
        chk("t5_ir_cap", 64'(ins_ready), 64'(0));
        chk("t5_mr_cap", 64'(mem_ready), 64'(2'b10));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_ov",   64'(outs_valid), 64'(0));
        chk("t5_outs", 64'(outs),       64'(0));
        chk("t5_ir",   64'(ins_ready),  64'(1));
        chk("t5_mr",   64'(mem_ready),  64'(2'b11));
        mem_valid = 2'b10;
        step();
        mem_valid = '0;
        step(); step();
        chk("t5_ov_idle",  64'(outs_valid),   64'(0));
        chk("t5_cnt_idle", 64'(obs_q.size()), 64'(0));
        ins = 32'h66660000; ins_valid = 1'b1; mem_valid = 2'b01;
        step();
        ins_valid = 1'b0; mem_valid = '0;
        chk("t5_ov_new",   64'(outs_valid), 64'(1));
        chk("t5_outs_new", 64'(outs),       64'(32'h66660000));
        step();
        chk("t5_cnt", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() == 1) chk("t5_tok", 64'(obs_q[0]), 64'(32'h66660000));

        // Random valids, random gaps and random backpressure. Output order must match offer order.
        obs_q.delete();
        foreach (rnd_data[i]) rnd_data[i] = $urandom();
        k = 0;
        cyc = 0;
        while (obs_q.size() < N_RND && cyc < 20000) begin
            if (!ins_valid && k < N_RND && $urandom_range(0, 2) == 0) begin
                ins_valid = 1'b1;
                ins = rnd_data[k];
            end
            for (int i = 0; i < NM; i++) begin
                if (!mem_valid[i] && $urandom_range(0, 2) == 0) mem_valid[i] = 1'b1;
            end
            outs_ready = 1'($urandom_range(0, 1));
            fire_i = ins_valid && ins_ready;
            fire_m = mem_valid & mem_ready;
            step();
            cyc++;
            if (fire_i) begin
                ins_valid = 1'b0;
                k++;
            end
            mem_valid = mem_valid & ~fire_m;
        end
        chk("rnd_timeout", 64'(cyc < 20000), 64'(1));
        chk("rnd_offered", 64'(k),             64'(N_RND));
        chk("rnd_cnt",     64'(obs_q.size()), 64'(N_RND));
        for (int i = 0; i < N_RND; i++) begin
            if (i < obs_q.size()) chk($sformatf("rnd_tok%0d", i), 64'(obs_q[i]), 64'(rnd_data[i]));
        end
        ins_valid = 1'b0; mem_valid = '0; outs_ready = 1'b1;
        repeat (10) step();
        chk("rnd_no_extra", 64'(obs_q.size()), 64'(N_RND));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/handshake_end_sync.md
HANDSHAKE_END_SYNC -- requirements
Module: handshake_end_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the result data channel (ins/outs); legal range 1..64.
REQ-002 Parameter NUM_MEMS, default 2, number of memory-completion control channels; legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ins  input  DATA_WIDTH  result data token.
REQ-006 ins_valid  input  1  result token present.
REQ-007 ins_ready  output  1  block accepts result token.
REQ-008 mem_valid  input  NUM_MEMS  per-memory completion token present (dataless control channels).
REQ-009 mem_ready  output  NUM_MEMS  per-memory completion accepted.
REQ-010 outs  output  DATA_WIDTH  final result token.
REQ-011 outs_valid  output  1  final result present.
REQ-012 outs_ready  input  1  downstream accepts final result.

Function
REQ-013 A transfer on any channel SHALL occur only in a cycle where that channel's valid and ready are both 1 at the rising edge.
REQ-014 The block SHALL have two states: COLLECT (gathering tokens) and EMIT (presenting the final result).
REQ-015 In COLLECT, ins_ready SHALL be 1 iff the data-captured flag is 0; mem_ready[i] SHALL be 1 iff done flag i is 0.
REQ-016 On an ins transfer, ins SHALL be stored in the data register and the data-captured flag set.
REQ-017 On a mem[i] transfer, done flag i SHALL be set; further mem[i] tokens SHALL stall (mem_ready[i]=0) until the next COLLECT round.
REQ-018 Data and any subset of mem channels transferring in the same cycle SHALL all be recorded in that cycle.
REQ-019 COLLECT->EMIT SHALL occur at the edge where the data-captured flag and all NUM_MEMS done flags are set, counting transfers completing at that same edge.
REQ-020 Latency: outs_valid SHALL rise exactly one cycle after the last required transfer; no combinational path from any input valid to outs_valid or outs.
REQ-021 In EMIT, outs_valid SHALL be 1, outs SHALL equal the data register, and ins_ready and all mem_ready SHALL be 0.
REQ-022 outs and outs_valid SHALL hold stable in EMIT until an outs transfer (no token retraction).
REQ-023 On an outs transfer, all flags SHALL clear and the state SHALL return to COLLECT; the first new-round acceptance occurs in the following cycle (one-cycle bubble).
REQ-024 Tokens arriving in arbitrary order and with arbitrary gaps SHALL produce exactly one output token per round.
REQ-025 ins_ready and mem_ready SHALL depend only on registered state, never on outs_ready.

Reset
REQ-026 While rst=1 at a rising edge: state <= COLLECT, all flags <= 0, data register <= 0.
REQ-027 Reset values: outs_valid=0, outs=0, ins_ready=1, mem_ready=all ones (first cycle after reset).
REQ-028 Reset asserted mid-round or in EMIT SHALL discard all captured tokens without emitting.

Structure
REQ-029 The COLLECT/EMIT state encoding localparams SHALL reside in the shared handshake_pkg alongside other dataflow-component constants.
REQ-030 Per-channel sticky flag logic (set on transfer, clear on round end, clear on reset) SHALL be one sub-module, handshake_token_flag, instantiated NUM_MEMS+1 times.
REQ-031 The data register SHALL load only on an ins transfer.

Verification
REQ-032 Reset, then ins=0x07EA045C valid with mem_valid=2'b11 in the same cycle, outs_ready=1 -> outs_valid=1 with outs=0x07EA045C in the next cycle only; exactly one output.
REQ-033 mem[0] at cycle 2, ins=0x1234 at cycle 5, mem[1] at cycle 9 -> outs_valid rises at cycle 10; mem_ready[0]=0 during cycles 3-10.
REQ-034 Round complete, outs_ready=0 for 6 cycles -> outs_valid=1 and outs constant throughout; ins_ready=mem_ready=0; accepted on 7th cycle, ins_ready=1 in the cycle after.
REQ-035 Second ins token (0xBEEF) offered while first (0x0001) captured -> ins_ready=0, 0xBEEF held upstream, outs=0x0001; 0xBEEF accepted in the next round.
REQ-036 rst pulsed one cycle after capturing data and mem[0] (mem[1] pending) -> no output; post-reset, full new round emits only the new data.
REQ-037 Randomized valid/ready with NUM_MEMS=1 and 8, 1000 rounds -> output token count equals round count, data order preserved.
